// File: rtl/chip8_pkg.sv
// Shared constants for the CHIP-8 PC sequencer: op codes, FSM encodings and reset address.
package chip8_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_SKIP = 3'd2;
    localparam logic [2:0] OP_JUMP = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CALL_JMP = 2'd1;
    localparam logic [1:0] ST_RET_LD   = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

    // CHIP-8 programs are loaded at 0x200; the lower space holds the interpreter.
    localparam int unsigned PC_RESET_DEFAULT = 32'h200;

endpackage

// File: rtl/chip8_pc_sequencer_if.sv
// Op handshake between the core's execute/writeback FSM (master) and the PC sequencer (slave).
interface chip8_pc_sequencer_if #(
    parameter int ADDR_W = 12
);
    import chip8_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [ADDR_W-1:0] jump_addr;

    modport master (output op_valid, output op_code, output jump_addr, input op_ready);
    modport slave  (input op_valid, input op_code, input jump_addr, output op_ready);

endinterface

// File: rtl/chip8_ret_stack.sv
// Return-address LIFO storage: one synchronous write port, one asynchronous read port.
module chip8_ret_stack #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 12,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] data,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Entry write; contents are never reset because sp alone decides validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= data;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/chip8_pc_sequencer.sv
// CHIP-8 program counter and call-stack sequencer.
// Define CHIP8_STACK_TRAP_EN to trap stack overflow/underflow into a FAULT state.
module chip8_pc_sequencer
    import chip8_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          STACK_DEPTH = 16,
    parameter int unsigned PC_RESET    = PC_RESET_DEFAULT,
    parameter int          INSTR_BYTES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    chip8_pc_sequencer_if.slave                op,
    output logic [ADDR_W-1:0]                  pc,
    output logic                               pc_upd,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_sticky,
    output logic                               unf_sticky
);

    localparam int                SP_W      = $clog2(STACK_DEPTH + 1);
    localparam int                AW        = $clog2(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(PC_RESET);
    localparam logic [ADDR_W-1:0] INC_STEP  = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] SKIP_STEP = ADDR_W'(2 * INSTR_BYTES);
    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]   SP_ONE    = SP_W'(32'd1);

    logic [1:0]        state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [ADDR_W-1:0] target_r, target_nxt_s;
    logic [ADDR_W-1:0] pc_inc_s, pc_skip_s, rd_data_s;
    logic [SP_W-1:0]   sp_r, sp_nxt_s;
    logic              upd_r, upd_nxt_s;
    logic              ovf_r, ovf_nxt_s;
    logic              unf_r, unf_nxt_s;
    logic              full_r, empty_r;
    logic              accept_s, we_s;

    assign pc_inc_s    = pc_r + INC_STEP;
    assign pc_skip_s   = pc_r + SKIP_STEP;
    assign op.op_ready = (state_r == ST_IDLE);
    assign accept_s    = op.op_valid && (state_r == ST_IDLE);

    // The pushed return address is the instruction after the CALL.
    chip8_ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W),
        .AW     (AW)
    ) u_stack (
        .clk   (clk),
        .we    (we_s),
        .addr  (sp_r[AW-1:0]),
        .data  (pc_inc_s),
        .raddr (sp_r[AW-1:0]),
        .rdata (rd_data_s)
    );

    // Next-state, next-PC and stack-pointer decisions for the sequencer FSM.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        sp_nxt_s     = sp_r;
        target_nxt_s = target_r;
        upd_nxt_s    = 1'b0;
        ovf_nxt_s    = ovf_r;
        unf_nxt_s    = unf_r;
        we_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op.op_code)
                        OP_HOLD: upd_nxt_s = 1'b0;
                        OP_INC: begin
                            pc_nxt_s  = pc_inc_s;
                            upd_nxt_s = 1'b1;
                        end
                        OP_SKIP: begin
                            pc_nxt_s  = pc_skip_s;
                            upd_nxt_s = 1'b1;
                        end
                        OP_JUMP: begin
                            pc_nxt_s  = op.jump_addr;
                            upd_nxt_s = 1'b1;
                        end
                        OP_CALL: begin
                            if (full_r) begin
                                ovf_nxt_s = 1'b1;
`ifdef CHIP8_STACK_TRAP_EN
                                state_nxt_s = ST_FAULT;
`else
                                pc_nxt_s  = op.jump_addr;
                                upd_nxt_s = 1'b1;
`endif
                            end else begin
                                we_s         = 1'b1;
                                target_nxt_s = op.jump_addr;
                                state_nxt_s  = ST_CALL_JMP;
                            end
                        end
                        OP_RET: begin
                            if (empty_r) begin
                                unf_nxt_s = 1'b1;
`ifdef CHIP8_STACK_TRAP_EN
                                state_nxt_s = ST_FAULT;
`else
                                pc_nxt_s  = pc_inc_s;
                                upd_nxt_s = 1'b1;
`endif
                            end else begin
                                sp_nxt_s    = sp_r - SP_ONE;
                                state_nxt_s = ST_RET_LD;
                            end
                        end
                        default: upd_nxt_s = 1'b0;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALL_JMP: begin
                pc_nxt_s    = target_r;
                sp_nxt_s    = sp_r + SP_ONE;
                upd_nxt_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            ST_RET_LD: begin
                pc_nxt_s    = rd_data_s;
                upd_nxt_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
`ifdef CHIP8_STACK_TRAP_EN
            ST_FAULT: state_nxt_s = ST_FAULT;
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State registers; full/empty are registered from the next sp so they track sp exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            pc_r     <= PC_RST;
            sp_r     <= {SP_W{1'b0}};
            target_r <= PC_RST;
            upd_r    <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            sp_r     <= sp_nxt_s;
            target_r <= target_nxt_s;
            upd_r    <= upd_nxt_s;
            ovf_r    <= ovf_nxt_s;
            unf_r    <= unf_nxt_s;
            full_r   <= (sp_nxt_s == SP_FULL);
            empty_r  <= (sp_nxt_s == {SP_W{1'b0}});
        end
    end

    assign pc          = pc_r;
    assign pc_upd      = upd_r;
    assign sp          = sp_r;
    assign stack_full  = full_r;
    assign stack_empty = empty_r;
    assign ovf_sticky  = ovf_r;
    assign unf_sticky  = unf_r;

endmodule

// File: tb/tb_chip8_pc_sequencer.sv
// Scoreboard bench for chip8_pc_sequencer (default build, no stack trap).
module tb_chip8_pc_sequencer;
    import chip8_pkg::*;

    localparam int AW    = 12;
    localparam int DEPTH = 16;
    localparam int SPW   = 5;
    localparam int MODV  = 4096;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  pc;
    logic           pc_upd;
    logic [SPW-1:0] sp;
    logic           stack_full, stack_empty, ovf_sticky, unf_sticky;

    chip8_pc_sequencer_if #(.ADDR_W(AW)) bus ();

    chip8_pc_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .PC_RESET    (32'h200),
        .INSTR_BYTES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (bus.slave),
        .pc          (pc),
        .pc_upd      (pc_upd),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_sticky  (ovf_sticky),
        .unf_sticky  (unf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int sp;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state: architectural PC, return stack as a queue, stickies.
    int   m_pc  = 32'h200;
    int   m_stk[$];
    bit   m_ovf = 1'b0;
    bit   m_unf = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model(int code, int addr);
        exp_t e;
        bit   pulse = 1'b1;
        case (code)
            1: m_pc = (m_pc + 2) % MODV;
            2: m_pc = (m_pc + 4) % MODV;
            3: m_pc = addr;
            4: begin
                if (m_stk.size() == DEPTH) m_ovf = 1'b1;
                else m_stk.push_back((m_pc + 2) % MODV);
                m_pc = addr;
            end
            5: begin
                if (m_stk.size() == 0) begin
                    m_unf = 1'b1;
                    m_pc  = (m_pc + 2) % MODV;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end
            default: pulse = 1'b0;
        endcase
        if (pulse) begin
            e.pc  = m_pc;
            e.sp  = m_stk.size();
            e.ovf = m_ovf;
            e.unf = m_unf;
            sb.push_back(e);
        end
    endfunction

    function automatic void model_reset();
        m_pc = 32'h200;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input int code, input int addr);
        int n = 0;
        while (!bus.op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(bus.op_ready), 1);
        bus.op_valid  = 1'b1;
        bus.op_code   = code[2:0];
        bus.jump_addr = addr[AW-1:0];
        model(code, addr);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    // Monitor: pops an expectation on every pc_upd pulse, otherwise pc must hold.
    initial begin : monitor
        exp_t e;
        bit   r;
        int   mon_pc = 32'h200;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            if (r) begin
                sb.delete();
                mon_pc = 32'h200;
            end else if (pc_upd) begin
                if (sb.size() == 0) begin
                    chk("spurious_pc_upd", 1, 0);
                end else begin
                    e = sb.pop_front();
                    mon_pc = e.pc;
                    chk("pc", int'(pc), e.pc);
                    chk("sp", int'(sp), e.sp);
                    chk("stack_full", int'(stack_full), int'(e.sp == DEPTH));
                    chk("stack_empty", int'(stack_empty), int'(e.sp == 0));
                    chk("ovf_sticky", int'(ovf_sticky), int'(e.ovf));
                    chk("unf_sticky", int'(unf_sticky), int'(e.unf));
                end
            end else begin
                chk("pc_hold", int'(pc), mon_pc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int codes[10] = '{0, 1, 2, 3, 4, 4, 5, 5, 6, 7};
        int exp_pc;
        bus.op_valid  = 1'b0;
        bus.op_code   = 3'd0;
        bus.jump_addr = 12'h000;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pc", int'(pc), 32'h200);
        chk("rst_sp", int'(sp), 0);
        chk("rst_empty", int'(stack_empty), 1);
        chk("rst_full", int'(stack_full), 0);
        chk("rst_ready", int'(bus.op_ready), 1);
        chk("rst_pc_upd", int'(pc_upd), 0);
        chk("rst_ovf", int'(ovf_sticky), 0);
        chk("rst_unf", int'(unf_sticky), 0);

        // Modular wrap of INC and SKIP, plus HOLD and reserved codes
        issue(3, 32'hFFC);
        issue(1, 0);
        issue(1, 0);
        issue(3, 32'hFFE);
        issue(2, 0);
        issue(0, 0);
        issue(6, 32'h123);
        issue(7, 32'h456);

        // Single CALL/RET pair
        issue(3, 32'h210);
        issue(4, 32'h300);
        chk("call_busy", int'(bus.op_ready), 0);
        @(negedge clk);
        chk("call_ready_back", int'(bus.op_ready), 1);
        chk("call_pc", int'(pc), 32'h300);
        chk("call_sp", int'(sp), 1);
        issue(5, 0);
        chk("ret_busy", int'(bus.op_ready), 0);
        @(negedge clk);
        chk("ret_pc", int'(pc), 32'h212);
        chk("ret_sp", int'(sp), 0);

        // Fill the stack, then overflow
        for (int i = 0; i < DEPTH; i++) issue(4, $urandom_range(0, 4095));
        @(negedge clk);
        chk("full_after_16", int'(stack_full), 1);
        chk("sp_after_16", int'(sp), DEPTH);
        issue(4, 32'h5A0);
        chk("ovf_pc", int'(pc), 32'h5A0);
        chk("ovf_sp", int'(sp), DEPTH);
        chk("ovf_flag", int'(ovf_sticky), 1);
        chk("ovf_ready", int'(bus.op_ready), 1);

        // Drain, then underflow
        for (int i = 0; i < DEPTH; i++) issue(5, 0);
        @(negedge clk);
        chk("empty_after_drain", int'(stack_empty), 1);
        exp_pc = (m_pc + 2) % MODV;
        issue(5, 0);
        chk("unf_pc", int'(pc), exp_pc);
        chk("unf_flag", int'(unf_sticky), 1);
        chk("unf_sp", int'(sp), 0);

        // Reset during the CALL_JMP cycle
        issue(4, 32'h400);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midcall_pc", int'(pc), 32'h200);
        chk("midcall_sp", int'(sp), 0);
        chk("midcall_ovf", int'(ovf_sticky), 0);
        chk("midcall_unf", int'(unf_sticky), 0);
        chk("midcall_ready", int'(bus.op_ready), 1);
        @(negedge clk);
        chk("midcall_stable_pc", int'(pc), 32'h200);
        chk("midcall_no_upd", int'(pc_upd), 0);

        // Randomised op stream
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(codes[$urandom_range(0, 9)], $urandom_range(0, 4095));
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
